// File: rtl/rob_multiport.sv
`default_nettype none
// ============================================================================
// Module   : rob_multiport
// Purpose  : Multi-port reorder buffer with in-order alloc/commit, out-of-order
//            writeback, head store sequencing, exception and mispredict report.
//            Optional perf counters when ROB_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rob_multiport #(
    parameter int DEPTH    = 16,
    parameter int ALLOC_W  = 2,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic [ALLOC_W-1:0]      alloc_valid,
    output logic                    alloc_ready,
    input  logic [ALLOC_W*22-1:0]   alloc_info,
    output logic [ALLOC_W*AW-1:0]   alloc_idx,
    input  logic [WB_PORTS-1:0]     wb_valid,
    input  logic [WB_PORTS*AW-1:0]  wb_idx,
    input  logic [WB_PORTS-1:0]     wb_ex,
    input  logic [WB_PORTS*5-1:0]   wb_exccode,
    input  logic [WB_PORTS-1:0]     wb_mispredict,
    output logic                    store_req_valid,
    output logic [AW-1:0]           store_req_idx,
    input  logic                    store_ack,
    input  logic                    store_ex,
    input  logic [4:0]              store_exccode,
    output logic [COMMIT_W-1:0]     commit_valid,
    output logic [COMMIT_W*18-1:0]  commit_info,
    output logic                    redirect_valid,
    output logic                    exception_valid,
    output logic [4:0]              exception_code,
    output logic [AW:0]             count,
    output logic                    empty
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_commit_cnt,
    output logic [31:0]             perf_full_cnt
`endif
);

    localparam logic [1:0] c_INVALID    = 2'd0;
    localparam logic [1:0] c_BUSY       = 2'd1;
    localparam logic [1:0] c_STORE_WAIT = 2'd2;
    localparam logic [1:0] c_DONE       = 2'd3;

    logic [1:0]  r_state    [DEPTH];
    logic        r_is_br    [DEPTH];
    logic        r_is_store [DEPTH];
    logic        r_rf_we    [DEPTH];
    logic [4:0]  r_dest     [DEPTH];
    logic [5:0]  r_phy_dest [DEPTH];
    logic [5:0]  r_old_dest [DEPTH];
    logic        r_ex       [DEPTH];
    logic [4:0]  r_exccode  [DEPTH];
    logic        r_mispred  [DEPTH];

    logic [AW:0]         r_head;
    logic [AW:0]         r_tail;
    logic [AW:0]         w_count;
    logic [AW:0]         w_free;
    logic [AW:0]         w_alloc_n;
    logic [AW:0]         w_commit_n;
    logic                w_alloc_fire;
    logic [AW-1:0]       w_alloc_idx [ALLOC_W];
    logic [AW-1:0]       w_wb_idx    [WB_PORTS];
    logic [AW-1:0]       w_lane_idx  [COMMIT_W];
    logic [COMMIT_W-1:0] w_commit_valid;
    logic                w_redirect;
    logic                w_stop;
    logic                w_pair;
    logic [AW-1:0]       w_e;
    logic [AW-1:0]       w_n;

    assign w_count      = r_tail - r_head;
    assign w_free       = (AW+1)'(DEPTH) - w_count;
    assign count        = w_count;
    assign empty        = (w_count == '0);
    assign alloc_ready  = (w_free >= (AW+1)'(ALLOC_W));
    assign w_alloc_fire = alloc_valid[0] && alloc_ready;

    for (genvar i = 0; i < ALLOC_W; i++) begin : g_alloc
        logic w_unused_pad;
        assign w_alloc_idx[i]            = r_tail[AW-1:0] + AW'(i);
        assign alloc_idx[i*AW +: AW]     = w_alloc_idx[i];
        assign w_unused_pad              = |alloc_info[i*22 +: 2];
    end

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
        assign w_wb_idx[p] = wb_idx[p*AW +: AW];
    end

    for (genvar k = 0; k < COMMIT_W; k++) begin : g_commit
        assign w_lane_idx[k] = r_head[AW-1:0] + AW'(k);
        assign commit_info[k*18 +: 18] = {r_rf_we[w_lane_idx[k]] & w_commit_valid[k],
                                          r_dest[w_lane_idx[k]],
                                          r_phy_dest[w_lane_idx[k]],
                                          r_old_dest[w_lane_idx[k]]};
    end

    always_comb begin
        w_alloc_n = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_valid[i]) w_alloc_n = w_alloc_n + (AW+1)'(1);
        end
    end

    // Lanes retire in order; a branch claims the next lane for its delay slot
    // and closes the group behind it.
    always_comb begin
        w_commit_valid = '0;
        w_redirect     = 1'b0;
        w_stop         = 1'b0;
        w_pair         = 1'b0;
        w_e            = '0;
        w_n            = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            w_e = r_head[AW-1:0] + AW'(k);
            w_n = w_e + AW'(1);
            if (w_pair) begin
                w_commit_valid[k] = 1'b1;
                w_pair            = 1'b0;
                w_stop            = 1'b1;
            end else if (!w_stop) begin
                if ((AW+1)'(k) >= w_count || r_state[w_e] != c_DONE || r_ex[w_e] ||
                    (k > 0 && r_is_store[w_e])) begin
                    w_stop = 1'b1;
                end else if (r_is_br[w_e]) begin
                    if (k + 1 < COMMIT_W && (AW+1)'(k + 1) < w_count &&
                        r_state[w_n] == c_DONE && !r_ex[w_n]) begin
                        w_commit_valid[k] = 1'b1;
                        w_pair            = 1'b1;
                        w_redirect        = r_mispred[w_e];
                    end else begin
                        w_stop = 1'b1;
                    end
                end else begin
                    w_commit_valid[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_commit_n = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            if (w_commit_valid[k]) w_commit_n = w_commit_n + (AW+1)'(1);
        end
    end

    assign commit_valid   = w_commit_valid;
    assign redirect_valid = w_redirect;

    // The entry behind a retiring head may start draining in the same cycle.
    always_comb begin
        store_req_valid = 1'b0;
        store_req_idx   = '0;
        if (r_state[w_lane_idx[0]] == c_STORE_WAIT) begin
            store_req_valid = 1'b1;
            store_req_idx   = w_lane_idx[0];
        end else if (r_state[w_lane_idx[0]] == c_DONE && w_commit_valid[0] &&
                     r_state[w_lane_idx[1]] == c_STORE_WAIT) begin
            store_req_valid = 1'b1;
            store_req_idx   = w_lane_idx[1];
        end
    end

    assign exception_valid = (r_state[w_lane_idx[0]] == c_DONE) && r_ex[w_lane_idx[0]];
    assign exception_code  = exception_valid ? r_exccode[w_lane_idx[0]] : 5'd0;

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i]   <= c_INVALID;
                r_ex[i]      <= 1'b0;
                r_exccode[i] <= 5'd0;
                r_mispred[i] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < COMMIT_W; k++) begin
                if (w_commit_valid[k]) r_state[w_lane_idx[k]] <= c_INVALID;
            end
            if (store_req_valid && store_ack) begin
                r_state[store_req_idx]   <= c_DONE;
                r_ex[store_req_idx]      <= store_ex;
                r_exccode[store_req_idx] <= store_exccode;
            end
            // Ascending order lets the higher-numbered port win on a collision.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && r_state[w_wb_idx[p]] != c_INVALID) begin
                    r_state[w_wb_idx[p]]   <= (r_is_store[w_wb_idx[p]] && !wb_ex[p]) ?
                                              c_STORE_WAIT : c_DONE;
                    r_ex[w_wb_idx[p]]      <= wb_ex[p];
                    r_exccode[w_wb_idx[p]] <= wb_exccode[p*5 +: 5];
                    r_mispred[w_wb_idx[p]] <= wb_mispredict[p];
                end
            end
            if (w_alloc_fire) begin
                for (int i = 0; i < ALLOC_W; i++) begin
                    if (alloc_valid[i]) begin
                        r_state[w_alloc_idx[i]]    <= c_BUSY;
                        r_is_br[w_alloc_idx[i]]    <= alloc_info[i*22 + 21];
                        r_is_store[w_alloc_idx[i]] <= alloc_info[i*22 + 20];
                        r_rf_we[w_alloc_idx[i]]    <= alloc_info[i*22 + 19];
                        r_dest[w_alloc_idx[i]]     <= alloc_info[i*22 + 14 +: 5];
                        r_phy_dest[w_alloc_idx[i]] <= alloc_info[i*22 + 8 +: 6];
                        r_old_dest[w_alloc_idx[i]] <= alloc_info[i*22 + 2 +: 6];
                        r_ex[w_alloc_idx[i]]       <= 1'b0;
                        r_exccode[w_alloc_idx[i]]  <= 5'd0;
                        r_mispred[w_alloc_idx[i]]  <= 1'b0;
                    end
                end
                r_tail <= r_tail + w_alloc_n;
            end
            r_head <= r_head + w_commit_n;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [31:0] r_perf_commit;
    logic [31:0] r_perf_full;

    // Flush does not clear these; they span the whole run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_commit <= 32'd0;
            r_perf_full   <= 32'd0;
        end else begin
            r_perf_commit <= r_perf_commit + 32'(w_commit_n);
            r_perf_full   <= r_perf_full + {31'd0, alloc_valid[0] && !alloc_ready};
        end
    end

    assign perf_commit_cnt = r_perf_commit;
    assign perf_full_cnt   = r_perf_full;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_multiport
// Purpose  : Directed vector table plus hand sequences for rob_multiport.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic [1:0]  alloc_valid;
    logic        alloc_ready;
    logic [43:0] alloc_info;
    logic [7:0]  alloc_idx;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_idx;
    logic [1:0]  wb_ex;
    logic [9:0]  wb_exccode;
    logic [1:0]  wb_mispredict;
    logic        store_req_valid;
    logic [3:0]  store_req_idx;
    logic        store_ack;
    logic        store_ex;
    logic [4:0]  store_exccode;
    logic [1:0]  commit_valid;
    logic [35:0] commit_info;
    logic        redirect_valid;
    logic        exception_valid;
    logic [4:0]  exception_code;
    logic [4:0]  count;
    logic        empty;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rob_multiport dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_info     (alloc_info),
        .alloc_idx      (alloc_idx),
        .wb_valid       (wb_valid),
        .wb_idx         (wb_idx),
        .wb_ex          (wb_ex),
        .wb_exccode     (wb_exccode),
        .wb_mispredict  (wb_mispredict),
        .store_req_valid(store_req_valid),
        .store_req_idx  (store_req_idx),
        .store_ack      (store_ack),
        .store_ex       (store_ex),
        .store_exccode  (store_exccode),
        .commit_valid   (commit_valid),
        .commit_info    (commit_info),
        .redirect_valid (redirect_valid),
        .exception_valid(exception_valid),
        .exception_code (exception_code),
        .count          (count),
        .empty          (empty)
    );

    typedef struct packed {
        logic        fl;
        logic [1:0]  av;
        logic [43:0] ai;
        logic [1:0]  wv;
        logic [7:0]  wi;
        logic [1:0]  wx;
        logic [9:0]  wc;
        logic [1:0]  ecv;
        logic [4:0]  ecnt;
        logic        eexv;
        logic [4:0]  eexc;
        logic [7:0]  eaidx;
        logic [35:0] eci;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [21:0] info(input logic br, input logic st, input logic we,
                                         input logic [4:0] d, input logic [5:0] pd,
                                         input logic [5:0] od);
        return {br, st, we, d, pd, od, 2'b00};
    endfunction

    function automatic vec_t mk(input logic fl, input logic [1:0] av, input logic [43:0] ai,
                                input logic [1:0] wv, input logic [7:0] wi,
                                input logic [1:0] wx, input logic [9:0] wc,
                                input logic [1:0] ecv, input logic [4:0] ecnt,
                                input logic eexv, input logic [4:0] eexc,
                                input logic [7:0] eaidx, input logic [35:0] eci);
        vec_t v;
        v.fl = fl; v.av = av; v.ai = ai; v.wv = wv; v.wi = wi; v.wx = wx; v.wc = wc;
        v.ecv = ecv; v.ecnt = ecnt; v.eexv = eexv; v.eexc = eexc; v.eaidx = eaidx; v.eci = eci;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0; alloc_valid = '0; alloc_info = '0;
        wb_valid = '0; wb_idx = '0; wb_ex = '0; wb_exccode = '0; wb_mispredict = '0;
        store_ack = 1'b0; store_ex = 1'b0; store_exccode = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [21:0] a0, a1, br_i, ds_i, st_i;

    initial begin
        reset = 1'b1;
        idle_inputs();
        a0   = info(1'b0, 1'b0, 1'b1, 5'd3, 6'd10, 6'd3);
        a1   = info(1'b0, 1'b0, 1'b1, 5'd4, 6'd11, 6'd4);
        br_i = info(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
        ds_i = info(1'b0, 1'b0, 1'b1, 5'd5, 6'd12, 6'd5);
        st_i = info(1'b0, 1'b1, 1'b0, 5'd0, 6'd0, 6'd0);

        vecs[0]  = mk(0, 2'b11, {a1, a0},   2'b00, 8'h00, 2'b00, 10'h000, 2'b00, 5'd0, 0, 5'h00, 8'h10, 36'h0);
        vecs[1]  = mk(0, 2'b00, 44'h0,      2'b11, 8'h10, 2'b00, 10'h000, 2'b00, 5'd2, 0, 5'h00, 8'h32, 36'h0);
        vecs[2]  = mk(0, 2'b00, 44'h0,      2'b00, 8'h00, 2'b00, 10'h000, 2'b11, 5'd2, 0, 5'h00, 8'h32,
                      {1'b1, 5'd4, 6'd11, 6'd4, 1'b1, 5'd3, 6'd10, 6'd3});
        vecs[3]  = mk(0, 2'b00, 44'h0,      2'b00, 8'h00, 2'b00, 10'h000, 2'b00, 5'd0, 0, 5'h00, 8'h32, 36'h0);
        vecs[4]  = mk(0, 2'b01, {22'h0, a0}, 2'b00, 8'h00, 2'b00, 10'h000, 2'b00, 5'd0, 0, 5'h00, 8'h32, 36'h0);
        vecs[5]  = mk(0, 2'b00, 44'h0,      2'b11, 8'h22, 2'b10, {5'h0A, 5'h00}, 2'b00, 5'd1, 0, 5'h00, 8'h43, 36'h0);
        vecs[6]  = mk(0, 2'b00, 44'h0,      2'b00, 8'h00, 2'b00, 10'h000, 2'b00, 5'd1, 1, 5'h0A, 8'h43, 36'h0);
        vecs[7]  = mk(0, 2'b00, 44'h0,      2'b00, 8'h00, 2'b00, 10'h000, 2'b00, 5'd1, 1, 5'h0A, 8'h43, 36'h0);
        vecs[8]  = mk(1, 2'b11, {a1, a0},   2'b01, 8'h02, 2'b00, 10'h000, 2'b00, 5'd1, 1, 5'h0A, 8'h43, 36'h0);
        vecs[9]  = mk(0, 2'b00, 44'h0,      2'b00, 8'h00, 2'b00, 10'h000, 2'b00, 5'd0, 0, 5'h00, 8'h10, 36'h0);
        vecs[10] = mk(0, 2'b00, 44'h0,      2'b01, 8'h02, 2'b01, {5'd0, 5'd3}, 2'b00, 5'd0, 0, 5'h00, 8'h10, 36'h0);
        vecs[11] = mk(0, 2'b00, 44'h0,      2'b00, 8'h00, 2'b00, 10'h000, 2'b00, 5'd0, 0, 5'h00, 8'h10, 36'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready",   32'(alloc_ready), 32'd1);
        chk("rst_empty",   32'(empty), 32'd1);
        chk("rst_count",   32'(count), 32'd0);
        chk("rst_cv",      32'(commit_valid), 32'd0);
        chk("rst_exv",     32'(exception_valid), 32'd0);
        chk("rst_exc",     32'(exception_code), 32'd0);
        chk("rst_sreq",    32'(store_req_valid), 32'd0);
        chk("rst_redir",   32'(redirect_valid), 32'd0);
        chk("rst_aidx",    32'(alloc_idx), 32'h10);

        for (int i = 0; i < 12; i++) begin
            flush_i = vecs[i].fl; alloc_valid = vecs[i].av; alloc_info = vecs[i].ai;
            wb_valid = vecs[i].wv; wb_idx = vecs[i].wi; wb_ex = vecs[i].wx;
            wb_exccode = vecs[i].wc; wb_mispredict = '0;
            #1;
            chk($sformatf("v%0d_cv", i),    32'(commit_valid), 32'(vecs[i].ecv));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].ecnt));
            chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(vecs[i].ecnt <= 5'd14));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].ecnt == 5'd0));
            chk($sformatf("v%0d_exv", i),   32'(exception_valid), 32'(vecs[i].eexv));
            chk($sformatf("v%0d_exc", i),   32'(exception_code), 32'(vecs[i].eexc));
            chk($sformatf("v%0d_aidx", i),  32'(alloc_idx), 32'(vecs[i].eaidx));
            if (vecs[i].ecv != 2'b00) begin
                chk($sformatf("v%0d_ci_lo", i), 32'(commit_info[17:0]),  32'(vecs[i].eci[17:0]));
                chk($sformatf("v%0d_ci_hi", i), 32'(commit_info[35:18]), 32'(vecs[i].eci[35:18]));
            end
            cyc();
        end
        idle_inputs();

        // Fill to 15, check backpressure, drain two, then wrap the tail.
        flush_i = 1'b1; cyc(); flush_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            alloc_valid = 2'b11; alloc_info = {a1, a0}; cyc();
        end
        alloc_valid = 2'b01; cyc(); alloc_valid = 2'b00; #1;
        chk("full_count", 32'(count), 32'd15);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        alloc_valid = 2'b11; cyc(); alloc_valid = 2'b00; #1;
        chk("full_blocked_count", 32'(count), 32'd15);
        wb_valid = 2'b11; wb_idx = 8'h10; cyc(); wb_valid = 2'b00; #1;
        chk("full_cv", 32'(commit_valid), 32'd3);
        cyc(); #1;
        chk("drain_count", 32'(count), 32'd13);
        chk("drain_ready", 32'(alloc_ready), 32'd1);
        alloc_valid = 2'b11; #1;
        chk("wrap_aidx", 32'(alloc_idx), 32'h0F);
        cyc(); alloc_valid = 2'b00; #1;
        chk("wrap_count", 32'(count), 32'd15);
        chk("wrap_aidx_next", 32'(alloc_idx), 32'h21);

        // Mispredicted branch waits for its delay slot, then both retire.
        flush_i = 1'b1; cyc(); flush_i = 1'b0;
        alloc_valid = 2'b11; alloc_info = {ds_i, br_i}; cyc(); alloc_valid = 2'b00;
        wb_valid = 2'b01; wb_idx = 8'h00; wb_mispredict = 2'b01; cyc();
        wb_valid = 2'b00; wb_mispredict = 2'b00; #1;
        chk("br_wait_cv", 32'(commit_valid), 32'd0);
        chk("br_wait_redir", 32'(redirect_valid), 32'd0);
        cyc(); #1;
        chk("br_wait2_cv", 32'(commit_valid), 32'd0);
        wb_valid = 2'b01; wb_idx = 8'h01; cyc(); wb_valid = 2'b00; #1;
        chk("br_pair_cv", 32'(commit_valid), 32'd3);
        chk("br_pair_redir", 32'(redirect_valid), 32'd1);
        chk("br_pair_slot_we", 32'(commit_info[35]), 32'd1);
        cyc(); #1;
        chk("br_after_count", 32'(count), 32'd0);
        chk("br_after_redir", 32'(redirect_valid), 32'd0);

        // Faulting store at head: reports exception, never retires.
        flush_i = 1'b1; cyc(); flush_i = 1'b0;
        alloc_valid = 2'b01; alloc_info = {22'h0, st_i}; cyc(); alloc_valid = 2'b00; #1;
        chk("st_busy_sreq", 32'(store_req_valid), 32'd0);
        wb_valid = 2'b01; wb_idx = 8'h00; cyc(); wb_valid = 2'b00; #1;
        chk("st_sreq", 32'(store_req_valid), 32'd1);
        chk("st_sidx", 32'(store_req_idx), 32'd0);
        chk("st_wait_cv", 32'(commit_valid), 32'd0);
        store_ack = 1'b1; store_ex = 1'b1; store_exccode = 5'h05; cyc();
        store_ack = 1'b0; store_ex = 1'b0; store_exccode = 5'h00; #1;
        chk("st_exv", 32'(exception_valid), 32'd1);
        chk("st_exc", 32'(exception_code), 32'h05);
        chk("st_ex_cv", 32'(commit_valid), 32'd0);
        chk("st_ex_sreq", 32'(store_req_valid), 32'd0);
        cyc(); #1;
        chk("st_exv_hold", 32'(exception_valid), 32'd1);
        chk("st_hold_count", 32'(count), 32'd1);

        // Clean store: ack without fault lets it retire.
        flush_i = 1'b1; cyc(); flush_i = 1'b0; #1;
        chk("st_flush_exv", 32'(exception_valid), 32'd0);
        alloc_valid = 2'b01; alloc_info = {22'h0, st_i}; cyc(); alloc_valid = 2'b00;
        wb_valid = 2'b01; wb_idx = 8'h00; cyc(); wb_valid = 2'b00; #1;
        chk("st2_sreq", 32'(store_req_valid), 32'd1);
        store_ack = 1'b1; cyc(); store_ack = 1'b0; #1;
        chk("st2_cv", 32'(commit_valid), 32'd1);
        chk("st2_exv", 32'(exception_valid), 32'd0);
        cyc(); #1;
        chk("st2_count", 32'(count), 32'd0);
        chk("st2_empty", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
